// File: rtl/fifo_pkg.sv
// Shared defaults and helpers for the fifos library: default width/depth,
// pointer-width helper and the default occupancy count type.
package fifo_pkg;

  localparam int DEFAULT_N     = 32;
  localparam int DEFAULT_DEPTH = 4;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  localparam int DEFAULT_PW = $clog2(DEFAULT_DEPTH);

  // One extra bit so a completely full FIFO (count == DEPTH) is representable.
  typedef logic [DEFAULT_PW:0] count_t;

endpackage

// File: rtl/fifo_ptr.sv
// PW-bit circular pointer for ehr_cf_fifo; wraps DEPTH-1 -> 0 naturally
// because DEPTH is a power of two.
module fifo_ptr #(
  parameter int PW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  output logic [PW-1:0] ptr
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + 1'b1;
    end
  end

endmodule

// File: rtl/ehr_cf_fifo.sv
// Conflict-free circular-buffer FIFO with valid/ready on both ends.
// Optional macro BYPASS_EN: zero-latency pass-through while empty.
module ehr_cf_fifo
  import fifo_pkg::*;
#(
  parameter  int N     = DEFAULT_N,
  parameter  int DEPTH = DEFAULT_DEPTH,
  localparam int PW    = ptr_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enq_valid,
  input  logic [N-1:0]  enq_data,
  output logic          enq_ready,
  output logic          deq_valid,
  output logic [N-1:0]  deq_data,
  input  logic          deq_ready,
  output logic [PW:0]   count,
  output logic          full,
  output logic          empty
);

  logic [N-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          enq_fire;
  logic          deq_fire;
  logic          do_write;
  logic          do_read;

  assign full  = (count == (PW+1)'(DEPTH));
  assign empty = (count == '0);

`ifdef BYPASS_EN
  // While empty the producer drives the consumer directly; the element is
  // stored only when the consumer does not take it this cycle.
  logic pass_through;

  always_comb begin
    enq_ready = !full;
    deq_valid = empty ? enq_valid : 1'b1;
    deq_data  = empty ? enq_data  : mem[rd_ptr];
  end

  assign enq_fire     = enq_valid && enq_ready;
  assign deq_fire     = deq_valid && deq_ready;
  assign pass_through = empty && enq_fire && deq_fire;
  assign do_write     = rst && enq_fire && !pass_through;
  assign do_read      = rst && deq_fire && !empty;
`else
  always_comb begin
    enq_ready = !full;
    deq_valid = !empty;
    deq_data  = empty ? '0 : mem[rd_ptr];
  end

  assign enq_fire = enq_valid && enq_ready;
  assign deq_fire = deq_valid && deq_ready;
  assign do_write = rst && enq_fire;
  assign do_read  = rst && deq_fire;
`endif

  fifo_ptr #(.PW(PW)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .inc (do_write),
    .ptr (wr_ptr)
  );

  fifo_ptr #(.PW(PW)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .inc (do_read),
    .ptr (rd_ptr)
  );

  // Storage is deliberately left uncleared by reset; empty masks it on output.
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[wr_ptr] <= enq_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else begin
      case ({do_write, do_read})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: doc/ehr_cf_fifo.md
Name: ehr_cf_fifo

Overview:
Parameterized circular-buffer FIFO with valid/ready handshakes on both ends. It is the reader/writer pair around the team's two-port ephemeral-history storage: one side enqueues, the other dequeues, and both may fire in the same cycle. It sits between pipeline stages in the fifos library and replaces single-register staging where more than one element of slack is needed.

Parameters:
N, 32, data width in bits.
DEPTH, 4, number of storage entries; must be >= 2 and a power of two.
PW, $clog2(DEPTH), pointer width (derived, not overridable).

Ports:
clk  input  1  clock, all state updates on rising edge.
rst  input  1  reset, synchronous, active-low.
enq_valid  input  1  producer offers enq_data this cycle.
enq_data  input  N  data to enqueue.
enq_ready  output  1  FIFO can accept; enqueue fires when enq_valid & enq_ready.
deq_valid  output  1  deq_data holds a valid element.
deq_data  output  N  head element.
deq_ready  input  1  consumer takes head; dequeue fires when deq_valid & deq_ready.
count  output  PW+1  number of stored elements, 0..DEPTH.
full  output  1  count == DEPTH.
empty  output  1  count == 0.

Behaviour:
- Reset: rst==0 at a rising edge sets rd_ptr=0, wr_ptr=0, count=0. Outputs: enq_ready=1, deq_valid=0, full=0, empty=1, deq_data=0 (storage array is not cleared; deq_data is masked to 0 when empty). Reset mid-operation discards all contents in that cycle; no enqueue or dequeue fires in a reset cycle.
- enq_ready = !full and deq_valid = !empty: both combinational from registered state only, with no combinational path from enq_valid or deq_ready in the default build.
- Enqueue fire: mem[wr_ptr] <= enq_data; wr_ptr <= wr_ptr+1, wrapping DEPTH-1 -> 0.
- Dequeue fire: rd_ptr <= rd_ptr+1, wrapping. deq_data = mem[rd_ptr] combinationally.
- Latency is 1 cycle: an element enqueued at edge k is visible on deq_data after edge k.
- count update: +1 on enqueue only, -1 on dequeue only, unchanged on both or neither. Width PW+1 so that DEPTH is representable.
- Simultaneous enqueue and dequeue when 0<count<DEPTH: both fire, count unchanged, pointers both advance.
- Full: enq_ready=0 even if deq_ready=1 in the same cycle (conflict-free ordering; no full-pass-through). A dequeue frees the slot for the next cycle.
- Empty: deq_valid=0, and an enqueue in that cycle is not visible until the next cycle (default build).
- enq_data is ignored when no enqueue fires. deq_ready while empty has no effect.
- No overflow or underflow is possible through the handshake; count never leaves 0..DEPTH.

Optional Feature:
BYPASS_EN. When defined and empty==1: deq_valid = enq_valid, deq_data = enq_data, and enq_ready=1. If deq_ready=1, the element passes straight through without being written, and pointers and count are unchanged. If deq_ready=0, the element is stored normally. This gives 0-cycle latency when empty and creates a combinational path enq->deq. Without BYPASS_EN, behaviour is exactly as above.

Decomposition:
- Package fifo_pkg: default N/DEPTH localparams, a ptr_w(depth) function, and a typedef for the count type.
- One sub-module, fifo_ptr: a PW-bit wrapping pointer with inc enable and synchronous active-low reset. It is instantiated twice, for rd_ptr and wr_ptr.
- Storage array and count logic live in ehr_cf_fifo.

Test Plan:
- Reset: hold rst=0 for 4 cycles with enq_valid=1 -> count=0, empty=1, full=0, enq_ready=1, deq_valid=0, deq_data=0.
- Fill: enqueue 0xA0,0xA1,0xA2,0xA3 on consecutive cycles with deq_ready=0 -> count steps 1..4, full=1, enq_ready=0; a fifth enq 0xFF is not accepted.
- Drain and order: from full, deq_ready=1 for 4 cycles -> deq_data sequence 0xA0..0xA3, then empty=1, count=0.
- Wrap with simultaneous ops: keep count=2 while enqueueing cnt and dequeueing every cycle for 10 cycles -> count stays 2; outputs equal the inputs delayed by 2 accepted entries across pointer wrap.
- Full plus deq_ready: at full assert enq_valid=1 (0x55) and deq_ready=1 -> dequeue fires, enqueue does not, count=3; next cycle enqueue 0x55 is accepted.
- Reset mid-stream: with count=3, pull rst=0 for one cycle -> count=0 next cycle. BYPASS_EN build: empty, enq 0x77 with deq_ready=1 -> deq_data=0x77 the same cycle, count stays 0.
